mmio_uart_tx: RTL and testbench

//  Memory-mapped console transmitter on the core's data bus, beside data_mem.

---
 rtl/mmio_uart_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter. Bus stores to TXDATA queue bytes in a
// small circular FIFO; an 8N1 serializer drains the FIFO onto tx_o.
// Register window (offset from BASE_ADDR): 0x0 TXDATA, 0x4 STATUS,
// 0x8 CTRL, 0xC DROPCNT. Loads are combinational.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        sel_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode
  logic       w_hit;
  logic [1:0] w_off;
  logic       w_wr_tx;
  logic       w_wr_ctrl;

  // Control / status registers
  logic       r_enable;
  logic [7:0] r_dropcnt;

  // FIFO
  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW:0]   r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [7:0]       w_head;
  logic [7:0]       w_count8;

  // Serializer
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_tx;
  logic             w_tx_next;

  logic [31:0]      w_status;
  logic             w_unused;

  assign w_hit     = ce && (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = addr[3:2];
  assign w_wr_tx   = w_hit && we && (w_off == 2'd0);
  assign w_wr_ctrl = w_hit && we && (w_off == 2'd2);
  assign sel_o     = w_hit;

  assign w_full  = (r_count == FIFO_FULL);
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_pop   = (r_state == S_IDLE) && r_enable && !w_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push  = w_wr_tx && (!w_full || w_pop);
  assign w_drop  = w_wr_tx && !w_push;

  assign busy_o = (r_state != S_IDLE);
  assign tx_o   = r_tx;

  assign w_unused = ^{addr[1:0], data_i[31:8]};

  // Zero-extend the occupancy count into the 8-bit STATUS field
  always_comb begin
    w_count8             = '0;
    w_count8[FIFO_AW:0]  = r_count;
  end

  assign w_status = {16'h0000, w_count8, 5'b00000, busy_o, w_empty, w_full};

  // Combinational load data; zero whenever this block is not the load target
  always_comb begin
    data_o = '0;
    if (w_hit && !we) begin
      unique case (w_off)
        2'd0:    data_o = '0;
        2'd1:    data_o = w_status;
        2'd2:    data_o = {31'h0, r_enable};
        default: data_o = {24'h0, r_dropcnt};
      endcase
    end
  end

  // CTRL enable and saturating drop counter; a clear beats a same-cycle drop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable  <= 1'b1;
      r_dropcnt <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= data_i[0];
      end
      if (w_wr_ctrl && data_i[1]) begin
        r_dropcnt <= '0;
      end else if (w_drop && (r_dropcnt != 8'hFF)) begin
        r_dropcnt <= r_dropcnt + 1'b1;
      end
    end
  end

  // FIFO storage array, written on accepted pushes (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Serializer state register, bit timing, shift register and tx_o flop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  // Serializer next-state: one CLKS_PER_BIT window per start/data/stop bit
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    unique case (r_state)
      S_IDLE: begin
        w_bit_cnt_next = '0;
        w_bit_idx_next = '0;
        if (w_pop) begin
          w_shift_next = w_head;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_bit_cnt_next = '0;
          w_state_next   = S_DATA;
        end else begin
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_bit_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_shift_next   = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
      end
      default: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_bit_cnt_next = '0;
          w_state_next   = S_IDLE;
        end else begin
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
      end
    endcase
  end

  // Serial line level for the next cycle, decoded from next state and shift
  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a register-access vector table, a UART frame
// monitor backed by an expected-byte queue, and hand-written sequences for
// frame timing, full-FIFO push/pop overlap and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          CPB  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr   = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        sel_o;
  logic        tx_o;
  logic        busy_o;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .we    (we),
    .addr  (addr),
    .data_i(data_i),
    .data_o(data_o),
    .sel_o (sel_o),
    .tx_o  (tx_o),
    .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [7:0] sb_q[$];
  int         start_q[$];
  bit         mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Frame monitor: samples mid-bit, compares each completed frame with the queue
  initial begin : monitor
    logic       prev;
    logic [9:0] bits;
    bit         abort;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && tx_o === 1'b0) begin
        mon_busy = 1'b1;
        abort    = 1'b0;
        bits     = '0;
        start_q.push_back(cyc);
        for (int c = 0; c < 10 * CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) bits[c / CPB] = tx_o;
        end
        if (!abort) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_unexpected: got byte %h expected no frame", bits[8:1]);
          end else begin
            e = sb_q.pop_front();
            check("frame_byte", {24'h0, bits[8:1]}, {24'h0, e});
            check("frame_start_stop", {30'h0, bits[9], bits[0]}, 32'h2);
          end
        end
        mon_busy = 1'b0;
      end
      prev = tx_o;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_sel;
    logic [31:0] exp_rd;
    logic        push_exp;
    string       nm;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic s, input logic [31:0] r, input logic p, input string nm);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.exp_sel = s; v.exp_rd = r; v.push_exp = p; v.nm = nm;
    vt.push_back(v);
  endtask

  task automatic bus_op(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ce = 1'b1; we = w; addr = a; data_i = d;
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
  endtask

  task automatic drain(input int lim, input string nm);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || busy_o || mon_busy) && k < lim) begin
      @(posedge clk);
      k++;
    end
    check(nm, (k < lim) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    n_bad++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] pat;
    logic       exp_tx;
    bit         seen;

    // Vector table: register reads, window decode, enable-off FIFO fill and drops
    add(0, BASE + 32'h4,  0, 1, 32'h0000_0002, 0, "rd_status_reset");
    add(0, BASE + 32'h8,  0, 1, 32'h0000_0001, 0, "rd_ctrl_reset");
    add(0, BASE + 32'hC,  0, 1, 32'h0000_0000, 0, "rd_drop_reset");
    add(0, BASE + 32'h0,  0, 1, 32'h0000_0000, 0, "rd_txdata");
    add(0, BASE + 32'h10, 0, 0, 32'h0000_0000, 0, "rd_above_window");
    add(0, 32'h0000_0004, 0, 0, 32'h0000_0000, 0, "rd_datamem");
    add(0, BASE + 32'h6,  0, 1, 32'h0000_0002, 0, "rd_status_lowbits");
    add(1, BASE + 32'h8,  0, 1, 32'h0000_0000, 0, "wr_ctrl_off");
    add(0, BASE + 32'h8,  0, 1, 32'h0000_0000, 0, "rd_ctrl_off");
    for (int i = 0; i < 3; i++)
      add(1, BASE, 32'hAB00_0041 + 32'(i), 1, 0, 1, $sformatf("wr_tx_%0d", i));
    add(1, BASE + 32'h10, 32'h77, 0, 32'h0, 0, "wr_above_window");
    add(1, 32'h0000_0000, 32'h78, 0, 32'h0, 0, "wr_datamem");
    add(0, BASE + 32'h4,  0, 1, 32'h0000_0300, 0, "rd_status_3");
    for (int i = 3; i < 9; i++)
      add(1, BASE, 32'h0000_0041 + 32'(i), 1, 0, (i < 8), $sformatf("wr_tx_%0d", i));
    add(0, BASE + 32'h4,  0, 1, 32'h0000_0801, 0, "rd_status_full");
    add(0, BASE + 32'hC,  0, 1, 32'h0000_0001, 0, "rd_drop_1");
    add(1, BASE + 32'h4,  32'hFFFF_FFFF, 1, 0, 0, "wr_status_ign");
    add(1, BASE + 32'hC,  32'h0000_0000, 1, 0, 0, "wr_drop_ign");
    add(0, BASE + 32'h4,  0, 1, 32'h0000_0801, 0, "rd_status_still");
    add(0, BASE + 32'hC,  0, 1, 32'h0000_0001, 0, "rd_drop_still");
    add(1, BASE,          32'h4A, 1, 0, 0, "wr_tx_drop2");
    add(0, BASE + 32'hC,  0, 1, 32'h0000_0002, 0, "rd_drop_2");
    add(1, BASE + 32'h8,  32'h2, 1, 0, 0, "wr_ctrl_clear");
    add(0, BASE + 32'hC,  0, 1, 32'h0000_0000, 0, "rd_drop_cleared");
    add(0, BASE + 32'h8,  0, 1, 32'h0000_0000, 0, "rd_ctrl_after_clr");

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx_o), 32'd1);
    check("reset_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;

    foreach (vt[i]) begin
      bus_op(vt[i].we, vt[i].addr, vt[i].wdata);
      if (vt[i].push_exp) sb_q.push_back(vt[i].wdata[7:0]);
      @(negedge clk);
      check({vt[i].nm, "_sel"}, 32'(sel_o), 32'(vt[i].exp_sel));
      check({vt[i].nm, "_rd"}, data_o, vt[i].exp_rd);
    end
    bus_idle();

    // Enable: queued 0x41..0x48 go out in order, 161 cycles apart
    start_q.delete();
    bus_op(1, BASE + 32'h8, 32'h1);
    bus_idle();
    drain(4000, "drain_enable");
    check("frame_count", 32'(start_q.size()), 32'd8);
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("frame_spacing_%0d", i), 32'(start_q[i] - start_q[i-1]), 32'd161);

    // Single 0x55 frame: cycle-exact line levels and busy fall
    pat = 8'h55;
    sb_q.push_back(pat);
    bus_op(1, BASE, 32'h55);
    bus_idle();
    for (int k = 1; k <= 161; k++) begin
      @(posedge clk); #1;
      if (k <= 16)       exp_tx = 1'b0;
      else if (k <= 144) exp_tx = pat[(k - 17) / 16];
      else               exp_tx = 1'b1;
      check($sformatf("t55_tx_%0d", k), 32'(tx_o), 32'(exp_tx));
      check($sformatf("t55_busy_%0d", k), 32'(busy_o), (k <= 160) ? 32'd1 : 32'd0);
    end
    drain(1000, "drain_55");

    // Full FIFO, idle FSM, enable set: push on the pop edge is accepted
    bus_op(1, BASE + 32'h8, 32'h2);
    for (int i = 0; i < 8; i++) begin
      bus_op(1, BASE, 32'h60 + 32'(i));
      sb_q.push_back(8'h60 + 8'(i));
    end
    bus_op(1, BASE + 32'h8, 32'h1);
    bus_op(1, BASE, 32'h5A);
    sb_q.push_back(8'h5A);
    bus_op(0, BASE + 32'h4, 0);
    @(negedge clk);
    check("overlap_status", data_o, 32'h0000_0805);
    bus_op(0, BASE + 32'hC, 0);
    @(negedge clk);
    check("overlap_drop", data_o, 32'h0000_0000);
    bus_idle();
    drain(4000, "drain_overlap");

    // Reset during DATA bit 3 with three bytes queued
    bus_op(1, BASE, 32'h11);
    bus_op(1, BASE, 32'h22);
    bus_op(1, BASE, 32'h33);
    bus_op(1, BASE, 32'h44);
    bus_idle();
    repeat (66) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx", 32'(tx_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    ce = 1'b1; we = 1'b0; addr = BASE + 32'h4;
    @(negedge clk);
    check("midrst_status", data_o, 32'h0000_0002);
    check("midrst_sel", 32'(sel_o), 32'd1);
    bus_idle();
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) seen = 1'b1;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    sb_q.push_back(8'h3C);
    bus_op(1, BASE, 32'h3C);
    bus_idle();
    drain(1000, "drain_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
